// File: rtl/div_arbiter.sv
`default_nettype none
// div_arbiter: round-robin arbiter that shares one divider among N requesters.
// Divide-by-zero requests are answered locally and never reach the divider.
module div_arbiter #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  localparam int IW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] a_in,
  input  logic [N*WIDTH-1:0] b_in,
  output logic [N-1:0]       ack,
  output logic [WIDTH-1:0]   q_out,
  output logic [WIDTH-1:0]   r_out,
  output logic               busy,
  output logic [IW-1:0]      owner,
  output logic               div_start,
  output logic [WIDTH-1:0]   div_a,
  output logic [WIDTH-1:0]   div_b,
  input  logic               div_ready,
  input  logic               div_last,
  input  logic [WIDTH-1:0]   div_q,
  input  logic [WIDTH-1:0]   div_r
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    winner;
  logic             found;
  logic [WIDTH-1:0] win_a, win_b;

  // First pending requester at or after rr_ptr, wrapping modulo N.
  always_comb begin
    int sum;
    winner = rr_ptr;
    found  = 1'b0;
    for (int k = 0; k < N; k++) begin
      sum = int'(rr_ptr) + k;
      if (sum >= N) sum = sum - N;
      if (!found && req[IW'(sum)]) begin
        winner = IW'(sum);
        found  = 1'b1;
      end
    end
  end

  assign win_a = a_in[winner*WIDTH +: WIDTH];
  assign win_b = b_in[winner*WIDTH +: WIDTH];

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (found && div_ready) state_nx = (win_b == '0) ? S_RESP : S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (div_last) state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs depend on state and registers only, never on req.
  assign ack       = (state == S_RESP) ? ({{(N-1){1'b0}}, 1'b1} << owner) : '0;
  assign div_start = (state == S_ISSUE);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      q_out  <= '0;
      r_out  <= '0;
      div_a  <= '0;
      div_b  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (found && div_ready) begin
            owner <= winner;
            if (win_b == '0) begin
              q_out <= '1;
              r_out <= win_a;
            end else begin
              div_a <= win_a;
              div_b <= win_b;
            end
          end
        end
        S_WAIT: begin
          if (div_last) begin
            q_out <= div_q;
            r_out <= div_r;
          end
        end
        S_RESP: begin
          rr_ptr <= (int'(owner) == N - 1) ? '0 : owner + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_arbiter.sv
`default_nettype none
// tb_div_arbiter: directed self-checking bench; the bench plays the divider.
module tb_div_arbiter;

  localparam int WIDTH = 8;
  localparam int N     = 4;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*WIDTH-1:0] a_in, b_in;
  logic [N-1:0]     ack;
  logic [WIDTH-1:0] q_out, r_out;
  logic             busy;
  logic [1:0]       owner;
  logic             div_start;
  logic [WIDTH-1:0] div_a, div_b;
  logic             div_ready, div_last;
  logic [WIDTH-1:0] div_q, div_r;

  int total  = 0;
  int passed = 0;

  div_arbiter #(.WIDTH(WIDTH), .N(N)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .ack(ack), .q_out(q_out), .r_out(r_out), .busy(busy), .owner(owner),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_ready(div_ready), .div_last(div_last), .div_q(div_q), .div_r(div_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    a_in[i*WIDTH +: WIDTH] = a;
    b_in[i*WIDTH +: WIDTH] = b;
  endtask

  // Serve one division with the bench acting as a divider of latency lat.
  task automatic do_div(input int own, input logic [7:0] ea, input logic [7:0] eb,
                        input logic [7:0] eq, input logic [7:0] er, input int lat, input bit drop);
    int n;
    logic [3:0] eack;
    eack = 4'b0001 << own;
    n = 0;
    while (div_start !== 1'b1 && n < 20) begin step(); n++; end
    total++; if (div_start !== 1'b1) begin $display("FAIL start_timeout: div_start=%b want 1", div_start); return; end else passed++;
    total++; if (owner !== 2'(own)) $display("FAIL owner: got %0d want %0d", owner, own); else passed++;
    total++; if (div_a !== ea || div_b !== eb) $display("FAIL operands: got %0d/%0d want %0d/%0d", div_a, div_b, ea, eb); else passed++;
    step();
    for (int i = 0; i < lat; i++) begin
      total++; if (div_start !== 1'b0 || ack !== 4'b0 || div_a !== ea) $display("FAIL wait_quiet: start=%b ack=%b a=%0d", div_start, ack, div_a); else passed++;
      step();
    end
    div_q = div_a / div_b;
    div_r = div_a % div_b;
    div_last = 1'b1;
    step();
    div_last = 1'b0;
    total++; if (ack !== eack) $display("FAIL ack: got %b want %b", ack, eack); else passed++;
    total++; if (q_out !== eq || r_out !== er) $display("FAIL result: got q=%0d r=%0d want q=%0d r=%0d", q_out, r_out, eq, er); else passed++;
    if (drop) req[own] = 1'b0;
    step();
    total++; if (ack !== 4'b0) $display("FAIL ack_pulse: got %b want 0000", ack); else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    total++; if (ack !== 4'b0 || busy !== 1'b0 || div_start !== 1'b0) $display("FAIL reset_ctrl: ack=%b busy=%b start=%b want 0", ack, busy, div_start); else passed++;
    total++; if (owner !== 2'd0 || q_out !== 8'd0 || r_out !== 8'd0) $display("FAIL reset_regs: owner=%0d q=%0d r=%0d want 0", owner, q_out, r_out); else passed++;
    total++; if (div_a !== 8'd0 || div_b !== 8'd0) $display("FAIL reset_ops: a=%0d b=%0d want 0", div_a, div_b); else passed++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    set_op(2, 8'd100, 8'd7);
    req = 4'b0100;
    do_div(2, 8'd100, 8'd7, 8'd14, 8'd2, 2, 1'b1);
    total++; if (div_start !== 1'b0 || busy !== 1'b0) $display("FAIL single_idle: start=%b busy=%b want 0", div_start, busy); else passed++;
  endtask

  task automatic test_round_robin();
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < N; i++) set_op(i, 8'd20, 8'd3);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) do_div(i % N, 8'd20, 8'd3, 8'd6, 8'd2, 1, 1'b0);
    req = 4'b0000;
    step(); step();
  endtask

  task automatic test_div_zero();
    set_op(1, 8'd55, 8'd0);
    req = 4'b0010;
    step();
    total++; if (ack !== 4'b0010 || div_start !== 1'b0) $display("FAIL dz_ack: ack=%b start=%b want 0010/0", ack, div_start); else passed++;
    total++; if (q_out !== 8'hFF || r_out !== 8'd55) $display("FAIL dz_result: got q=%0d r=%0d want q=255 r=55", q_out, r_out); else passed++;
    req = 4'b0000;
    step();
    total++; if (ack !== 4'b0 || busy !== 1'b0 || div_start !== 1'b0) $display("FAIL dz_done: ack=%b busy=%b start=%b want 0", ack, busy, div_start); else passed++;
  endtask

  task automatic test_not_ready();
    div_ready = 1'b0;
    set_op(0, 8'd9, 8'd4);
    req = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (busy !== 1'b0 || div_start !== 1'b0) $display("FAIL not_ready_hold: busy=%b start=%b want 0", busy, div_start); else passed++;
    end
    div_ready = 1'b1;
    do_div(0, 8'd9, 8'd4, 8'd2, 8'd1, 1, 1'b1);
  endtask

  task automatic test_reset_mid();
    set_op(3, 8'd50, 8'd6);
    req = 4'b1000;
    step(); step();
    total++; if (busy !== 1'b1 || owner !== 2'd3) $display("FAIL rm_wait: busy=%b owner=%0d want 1/3", busy, owner); else passed++;
    #1 rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || ack !== 4'b0 || owner !== 2'd0 || q_out !== 8'd0) $display("FAIL rm_async: busy=%b ack=%b owner=%0d q=%0d want 0", busy, ack, owner, q_out); else passed++;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (ack !== 4'b0 || div_start !== 1'b0) $display("FAIL rm_noack: ack=%b start=%b want 0", ack, div_start); else passed++;
    end
    rst = 1'b0;
    do_div(3, 8'd50, 8'd6, 8'd8, 8'd2, 2, 1'b1);
  endtask

  task automatic test_spurious();
    int n;
    set_op(0, 8'd30, 8'd4);
    req = 4'b0001;
    n = 0;
    while (div_start !== 1'b1 && n < 20) begin step(); n++; end
    total++; if (div_start !== 1'b1) $display("FAIL sp_start: div_start=%b want 1", div_start); else passed++;
    div_q = 8'd99; div_r = 8'd99; div_last = 1'b1;
    step();
    div_last = 1'b0;
    req = 4'b0000;
    total++; if (q_out !== 8'd8 || ack !== 4'b0 || busy !== 1'b1) $display("FAIL sp_ignored: q=%0d ack=%b busy=%b want 8/0000/1", q_out, ack, busy); else passed++;
    step(); step();
    total++; if (ack !== 4'b0 || busy !== 1'b1) $display("FAIL sp_waiting: ack=%b busy=%b want 0000/1", ack, busy); else passed++;
    div_q = 8'd7; div_r = 8'd2; div_last = 1'b1;
    step();
    div_last = 1'b0;
    total++; if (ack !== 4'b0001 || q_out !== 8'd7 || r_out !== 8'd2) $display("FAIL sp_ack: ack=%b q=%0d r=%0d want 0001/7/2", ack, q_out, r_out); else passed++;
    step();
    total++; if (ack !== 4'b0 || busy !== 1'b0) $display("FAIL sp_once: ack=%b busy=%b want 0", ack, busy); else passed++;
    step(); step();
    total++; if (div_start !== 1'b0 || busy !== 1'b0) $display("FAIL sp_idle: start=%b busy=%b want 0", div_start, busy); else passed++;
  endtask

  initial begin
    rst = 1'b1; req = '0; a_in = '0; b_in = '0;
    div_ready = 1'b1; div_last = 1'b0; div_q = '0; div_r = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_div_zero();
    test_not_ready();
    test_reset_mid();
    test_spurious();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width.
REQ-002 Parameter N, default 4, number of requesters (>=2); IW = clog2(N).
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 req  in  N  bit i: requester i wants a division; held high until ack[i].
REQ-007 a_in  in  N*WIDTH  dividend, slice i for requester i.
REQ-008 b_in  in  N*WIDTH  divisor, slice i for requester i.
REQ-009 ack  out  N  one-cycle pulse, result for requester i valid.
REQ-010 q_out, r_out  out  WIDTH each  quotient/remainder, valid while ack nonzero, held until next capture.
REQ-011 busy  out  1  high in any state except IDLE.
REQ-012 owner  out  IW  index of requester currently served.
REQ-013 div_start  out  1  start pulse to divider.
REQ-014 div_a, div_b  out  WIDTH each  operands to divider.
REQ-015 div_ready  in  1  divider idle, accepts start.
REQ-016 div_last  in  1  divider result valid this cycle.
REQ-017 div_q, div_r  in  WIDTH each  divider quotient/remainder.

Function
REQ-018 FSM states IDLE, ISSUE, WAIT, RESP; registered state, single next-state block.
REQ-019 IDLE: if |req and div_ready, winner = first i with req[i]=1 scanning rr_ptr, rr_ptr+1, ... mod N; latch owner<=winner, div_a<=a_in[winner], div_b<=b_in[winner].
REQ-020 IDLE with |req and latched-candidate divisor b_in[winner]==0: skip divider, q_out<={WIDTH{1}}, r_out<=a_in[winner], owner<=winner, go RESP.
REQ-021 IDLE with div_ready=0 or req=0: remain IDLE, no latch.
REQ-022 ISSUE: div_start=1 for exactly this one cycle; next WAIT.
REQ-023 WAIT: div_a/div_b held stable; on div_last=1 capture q_out<=div_q, r_out<=div_r, go RESP.
REQ-024 div_last outside WAIT ignored.
REQ-025 RESP: ack[owner]=1 for one cycle, all other ack bits 0; rr_ptr<=(owner+1) mod N; next IDLE.
REQ-026 Latency: req seen in IDLE at cycle T -> div_start at T+1 -> ack one cycle after div_last; divide-by-zero ack at T+1.
REQ-027 At most one division outstanding; req of non-owners ignored until return to IDLE.
REQ-028 Owner deasserting req mid-operation: operation completes, ack still pulses.
REQ-029 Requester re-asserting req the cycle after its ack loses priority to any other pending requester (round-robin fairness, no starvation: every held req served within N grants).
REQ-030 ack, div_start are combinational decodes of state only; no combinational path from req to any output.

Reset
REQ-031 rst asynchronously forces state=IDLE, rr_ptr=0, owner=0, q_out=r_out=0, div_a=div_b=0; ack=0, div_start=0, busy=0.
REQ-032 rst mid-operation abandons the division, no ack issued; after release first grant searches from requester 0.

Verification
REQ-033 Single req[2]=1, a=100, b=7 -> one div_start, ack=4'b0100 with q_out=14, r_out=2.
REQ-034 req=4'b1111 held, all a=20,b=3 after reset -> acks in order 0,1,2,3,0, each q=6, r=2.
REQ-035 req[1]=1, b=0, a=55 -> no div_start, ack[1] one cycle after grant, q_out=8'hFF, r_out=55.
REQ-036 req[0] held while divider div_ready=0 for 5 cycles -> no grant until div_ready=1, then normal completion.
REQ-037 rst asserted in WAIT with req[3]=1 -> immediate IDLE, busy=0, no ack[3]; after release req[3] re-served with correct result.
REQ-038 Owner drops req in WAIT; spurious div_last in ISSUE -> ack still pulses once, capture only from WAIT-state div_last.
